// File: rtl/change_dispense_ctrl.sv
// change_dispense_ctrl
// Pays out change one coin at a time through a shared eject mechanism.
// It always pays the largest coin it can: 10, then 5, then 1.
// Three tube counters track the coins on hand. Coins routed in from the
// acceptor refill the tubes. Any amount that could not be paid is
// reported in done_short.
// Optional build macro CHANGE_DISPENSE_ACK_TIMEOUT_EN: gives up on an
// eject that is not acknowledged within ACK_TIMEOUT cycles and raises a
// sticky fault flag.
module change_dispense_ctrl #(
  parameter int AMT_W       = 6,
  parameter int CNT_W       = 5,
  parameter int TUBE10_INIT = 8,
  parameter int TUBE5_INIT  = 8,
  parameter int TUBE1_INIT  = 10,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amount,
  output logic             req_ready,
  input  logic             coin_in_valid,
  input  logic [1:0]       coin_in_type,
  output logic             eject_valid,
  output logic [1:0]       eject_type,
  input  logic             eject_ack,
  output logic             done,
  output logic [AMT_W-1:0] done_short,
  output logic             busy,
  output logic [CNT_W-1:0] cnt_10,
  output logic [CNT_W-1:0] cnt_5,
  output logic [CNT_W-1:0] cnt_1,
  output logic             exact_change_only,
  output logic             fault
);

  typedef enum logic [1:0] {S_IDLE, S_SELECT, S_EJECT, S_DONE} state_e;

  localparam logic [1:0]       COIN_NONE = 2'b00;
  localparam logic [1:0]       COIN_1    = 2'b01;
  localparam logic [1:0]       COIN_5    = 2'b10;
  localparam logic [1:0]       COIN_10   = 2'b11;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [AMT_W-1:0] VAL_1     = AMT_W'(1);
  localparam logic [AMT_W-1:0] VAL_5     = AMT_W'(5);
  localparam logic [AMT_W-1:0] VAL_10    = AMT_W'(10);

  // Monetary value of a coin code.
  function automatic logic [AMT_W-1:0] coin_value(input logic [1:0] t);
    case (t)
      COIN_10: return VAL_10;
      COIN_5:  return VAL_5;
      COIN_1:  return VAL_1;
      default: return '0;
    endcase
  endfunction

  // Tube update. An insert and an eject on the same tube in the same cycle
  // cancel out, so saturation and underflow only apply to a lone event.
  function automatic logic [CNT_W-1:0] tube_next(input logic [CNT_W-1:0] cnt,
                                                 input logic inc, input logic dec);
    if (inc && !dec) return (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    if (dec && !inc) return (cnt == '0) ? cnt : cnt - CNT_W'(1);
    return cnt;
  endfunction

  state_e           state_q, state_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic             eject_valid_q, eject_valid_d;
  logic [1:0]       eject_type_q, eject_type_d;
  logic [AMT_W-1:0] done_short_q, done_short_d;
  logic [CNT_W-1:0] cnt_10_q, cnt_5_q, cnt_1_q;
  logic [1:0]       dec_type;
  logic             elig_10, elig_5, elig_1;

`ifdef CHANGE_DISPENSE_ACK_TIMEOUT_EN
  localparam int               TMO_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             fault_q, fault_d;
`endif

  // A coin is eligible when it fits in the remainder and its tube is not empty.
  assign elig_10 = (rem_q >= VAL_10) && (cnt_10_q != '0);
  assign elig_5  = (rem_q >= VAL_5)  && (cnt_5_q  != '0);
  assign elig_1  = (rem_q >= VAL_1)  && (cnt_1_q  != '0);

  // Next-state, remainder and eject request logic.
  always_comb begin
    // NOTE: every signal gets a default first so that no path through the
    // case statement leaves a signal unassigned and infers a latch.
    state_d       = state_q;
    rem_d         = rem_q;
    eject_valid_d = eject_valid_q;
    eject_type_d  = eject_type_q;
    done_short_d  = done_short_q;
    dec_type      = COIN_NONE;
`ifdef CHANGE_DISPENSE_ACK_TIMEOUT_EN
    tmo_d         = tmo_q;
    fault_d       = fault_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          rem_d   = req_amount;
          state_d = S_SELECT;
        end
      end
      S_SELECT: begin
`ifdef CHANGE_DISPENSE_ACK_TIMEOUT_EN
        tmo_d = '0;
`endif
        if (elig_10 || elig_5 || elig_1) begin
          eject_valid_d = 1'b1;
          eject_type_d  = elig_10 ? COIN_10 : (elig_5 ? COIN_5 : COIN_1);
          state_d       = S_EJECT;
        end else begin
          done_short_d = rem_q;
          state_d      = S_DONE;
        end
      end
      S_EJECT: begin
        if (eject_ack) begin
          eject_valid_d = 1'b0;
          dec_type      = eject_type_q;
          rem_d         = rem_q - coin_value(eject_type_q);
          state_d       = S_SELECT;
        end
`ifdef CHANGE_DISPENSE_ACK_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          // The mechanism never answered: abandon the coin and report the
          // whole remainder as unpaid.
          eject_valid_d = 1'b0;
          fault_d       = 1'b1;
          done_short_d  = rem_q;
          state_d       = S_DONE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
`endif
      end
      default: state_d = S_IDLE;  // S_DONE lasts exactly one cycle
    endcase
  end

  // State, datapath and tube registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      rem_q         <= '0;
      eject_valid_q <= 1'b0;
      eject_type_q  <= COIN_NONE;
      done_short_q  <= '0;
      cnt_10_q      <= CNT_W'(TUBE10_INIT);
      cnt_5_q       <= CNT_W'(TUBE5_INIT);
      cnt_1_q       <= CNT_W'(TUBE1_INIT);
    end else begin
      // NOTE: non-blocking assignments make every register take its new value
      // at the same instant, so register order within this block does not matter.
      state_q       <= state_d;
      rem_q         <= rem_d;
      eject_valid_q <= eject_valid_d;
      eject_type_q  <= eject_type_d;
      done_short_q  <= done_short_d;
      cnt_10_q      <= tube_next(cnt_10_q, coin_in_valid && (coin_in_type == COIN_10),
                                 dec_type == COIN_10);
      cnt_5_q       <= tube_next(cnt_5_q, coin_in_valid && (coin_in_type == COIN_5),
                                 dec_type == COIN_5);
      cnt_1_q       <= tube_next(cnt_1_q, coin_in_valid && (coin_in_type == COIN_1),
                                 dec_type == COIN_1);
    end
  end

`ifdef CHANGE_DISPENSE_ACK_TIMEOUT_EN
  // Ack-wait counter and sticky fault flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      tmo_q   <= tmo_d;
      fault_q <= fault_d;
    end
  end
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  assign req_ready         = (state_q == S_IDLE);
  assign busy              = (state_q != S_IDLE);
  assign done              = (state_q == S_DONE);
  assign done_short        = done_short_q;
  assign eject_valid       = eject_valid_q;
  assign eject_type        = eject_type_q;
  assign cnt_10            = cnt_10_q;
  assign cnt_5             = cnt_5_q;
  assign cnt_1             = cnt_1_q;
  assign exact_change_only = (cnt_1_q < CNT_W'(4)) || (cnt_5_q == '0);

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// Testbench for change_dispense_ctrl.
// Instance A uses the default tube fill. Instance B starts with an empty
// 10 tube. Both instances share all inputs except req_valid. The "sel"
// signal chooses which instance's outputs are observed.
`timescale 1ns/1ps
module tb_change_dispense_ctrl;

  localparam int AMT_W = 6;
  localparam int CNT_W = 5;
  localparam int NEVER = 100000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid_a, req_valid_b;
  logic [AMT_W-1:0] req_amount;
  logic             coin_in_valid;
  logic [1:0]       coin_in_type;
  logic             eject_ack;

  logic             ready_a, ev_a, done_a, busy_a, exact_a, fault_a;
  logic             ready_b, ev_b, done_b, busy_b, exact_b, fault_b;
  logic [1:0]       et_a, et_b;
  logic [AMT_W-1:0] short_a, short_b;
  logic [CNT_W-1:0] c10_a, c5_a, c1_a, c10_b, c5_b, c1_b;

  logic             sel;
  logic             m_ready, m_ev, m_done, m_busy, m_exact, m_fault;
  logic [1:0]       m_et;
  logic [AMT_W-1:0] m_short;
  logic [CNT_W-1:0] m_c10, m_c5, m_c1;

  int n_checks = 0;
  int n_errors = 0;

  // Results of the most recent run_req call.
  int r_n10, r_n5, r_n1, r_short, r_lat, r_done, r_order, r_stable;

  always #5 clk = ~clk;

  change_dispense_ctrl dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_a), .req_amount(req_amount),
    .req_ready(ready_a), .coin_in_valid(coin_in_valid), .coin_in_type(coin_in_type),
    .eject_valid(ev_a), .eject_type(et_a), .eject_ack(eject_ack), .done(done_a),
    .done_short(short_a), .busy(busy_a), .cnt_10(c10_a), .cnt_5(c5_a), .cnt_1(c1_a),
    .exact_change_only(exact_a), .fault(fault_a)
  );

  change_dispense_ctrl #(.TUBE10_INIT(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_b), .req_amount(req_amount),
    .req_ready(ready_b), .coin_in_valid(coin_in_valid), .coin_in_type(coin_in_type),
    .eject_valid(ev_b), .eject_type(et_b), .eject_ack(eject_ack), .done(done_b),
    .done_short(short_b), .busy(busy_b), .cnt_10(c10_b), .cnt_5(c5_b), .cnt_1(c1_b),
    .exact_change_only(exact_b), .fault(fault_b)
  );

  assign m_ready = sel ? ready_b : ready_a;
  assign m_ev    = sel ? ev_b    : ev_a;
  assign m_et    = sel ? et_b    : et_a;
  assign m_done  = sel ? done_b  : done_a;
  assign m_short = sel ? short_b : short_a;
  assign m_busy  = sel ? busy_b  : busy_a;
  assign m_exact = sel ? exact_b : exact_a;
  assign m_fault = sel ? fault_b : fault_a;
  assign m_c10   = sel ? c10_b   : c10_a;
  assign m_c5    = sel ? c5_b    : c5_a;
  assign m_c1    = sel ? c1_b    : c1_a;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req_valid_a = 1'b0; req_valid_b = 1'b0; req_amount = '0;
    coin_in_valid = 1'b0; coin_in_type = 2'b00; eject_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Issues one request and plays the eject mechanism, acking each coin
  // after 'delay' extra wait cycles. If ins is nonzero, a coin of that type
  // is inserted in the same cycle as each ack. r_lat counts cycles from the
  // acceptance cycle to the cycle in which done is seen.
  task automatic run_req(input bit s, input int amount, input int delay,
                         input logic [1:0] ins);
    int         wait_cnt;
    logic [1:0] cur, prev;
    r_n10 = 0; r_n5 = 0; r_n1 = 0; r_short = -1; r_lat = 0;
    r_done = 0; r_order = 1; r_stable = 1;
    sel = s;
    @(negedge clk);
    check("ready_before_req", int'(m_ready), 1);
    if (s) req_valid_b = 1'b1; else req_valid_a = 1'b1;
    req_amount = AMT_W'(amount);
    wait_cnt = 0; prev = 2'b11; cur = 2'b00;
    for (int cyc = 1; cyc <= 400 && r_done == 0; cyc++) begin
      @(negedge clk);
      req_valid_a = 1'b0; req_valid_b = 1'b0;
      eject_ack = 1'b0; coin_in_valid = 1'b0; coin_in_type = 2'b00;
      if (m_done) begin
        r_done  = 1;
        r_lat   = cyc;
        r_short = int'(m_short);
      end else if (m_ev) begin
        if (wait_cnt == 0) cur = m_et;
        else if (m_et != cur) r_stable = 0;
        if (wait_cnt == delay) begin
          eject_ack = 1'b1;
          wait_cnt  = 0;
          case (cur)
            2'b11:   r_n10++;
            2'b10:   r_n5++;
            2'b01:   r_n1++;
            default: r_order = 0;
          endcase
          if (cur > prev) r_order = 0;
          prev = cur;
          if (ins != 2'b00) begin
            coin_in_valid = 1'b1;
            coin_in_type  = ins;
          end
        end else begin
          wait_cnt++;
        end
      end else if (wait_cnt != 0) begin
        r_stable = 0;  // eject_valid dropped before it was acknowledged
      end
    end
    eject_ack = 1'b0; coin_in_valid = 1'b0; coin_in_type = 2'b00;
    check("done_within_budget", r_done, 1);
  endtask

  typedef struct {
    bit sel;
    int amount, delay;
    int n10, n5, n1, short_amt;
    int c10, c5, c1, exact, lat;
  } vec_t;

  vec_t vecs[6];
  int   acks, seen_done;

  initial begin
    // sel amount delay | n10 n5 n1 short | c10 c5 c1 exact lat
    vecs[0] = '{1'b0, 37, 0,  3, 1,  2,  0,  5, 7, 8, 0, 14};
    vecs[1] = '{1'b0,  0, 0,  0, 0,  0,  0,  5, 7, 8, 0,  2};
    vecs[2] = '{1'b0, 15, 3,  1, 1,  0,  0,  4, 6, 8, 0, 12};
    vecs[3] = '{1'b0,  4, 1,  0, 0,  4,  0,  4, 6, 4, 0, 14};
    vecs[4] = '{1'b0,  1, 0,  0, 0,  1,  0,  4, 6, 3, 1,  4};
    vecs[5] = '{1'b1, 63, 0,  0, 8, 10, 13,  0, 0, 0, 1, 38};

    sel = 1'b0;
    apply_reset();

    // Reset state.
    check("rst_ready",      int'(ready_a), 1);
    check("rst_busy",       int'(busy_a), 0);
    check("rst_eject_vld",  int'(ev_a), 0);
    check("rst_eject_type", int'(et_a), 0);
    check("rst_done",       int'(done_a), 0);
    check("rst_done_short", int'(short_a), 0);
    check("rst_fault",      int'(fault_a), 0);
    check("rst_cnt_10",     int'(c10_a), 8);
    check("rst_cnt_5",      int'(c5_a), 8);
    check("rst_cnt_1",      int'(c1_a), 10);
    check("rst_exact",      int'(exact_a), 0);
    check("rst_b_cnt_10",   int'(c10_b), 0);

    // Table-driven requests.
    foreach (vecs[i]) begin
      run_req(vecs[i].sel, vecs[i].amount, vecs[i].delay, 2'b00);
      check($sformatf("v%0d_n10", i),    r_n10, vecs[i].n10);
      check($sformatf("v%0d_n5", i),     r_n5, vecs[i].n5);
      check($sformatf("v%0d_n1", i),     r_n1, vecs[i].n1);
      check($sformatf("v%0d_order", i),  r_order, 1);
      check($sformatf("v%0d_stable", i), r_stable, 1);
      check($sformatf("v%0d_short", i),  r_short, vecs[i].short_amt);
      check($sformatf("v%0d_latency", i), r_lat, vecs[i].lat);
      @(negedge clk);
      check($sformatf("v%0d_cnt_10", i), int'(m_c10), vecs[i].c10);
      check($sformatf("v%0d_cnt_5", i),  int'(m_c5), vecs[i].c5);
      check($sformatf("v%0d_cnt_1", i),  int'(m_c1), vecs[i].c1);
      check($sformatf("v%0d_exact", i),  int'(m_exact), vecs[i].exact);
      check($sformatf("v%0d_short_hold", i), int'(m_short), vecs[i].short_amt);
    end
    sel = 1'b0;

    // Insert a 5 on the ack cycle of a 5 eject: the tube must stay at 3.
    apply_reset();
    for (int k = 0; k < 5; k++) run_req(1'b0, 5, 0, 2'b00);
    @(negedge clk);
    check("drain_cnt_5", int'(c5_a), 3);
    run_req(1'b0, 5, 0, 2'b10);
    check("coll_n5", r_n5, 1);
    @(negedge clk);
    check("coll_cnt_5", int'(c5_a), 3);
    check("coll_cnt_10", int'(c10_a), 8);

    // Saturation of the 1 tube; 00 is ignored; 11 refills the 10 tube.
    apply_reset();
    coin_in_valid = 1'b1; coin_in_type = 2'b01;
    repeat (21) @(negedge clk);
    check("fill_cnt_1", int'(c1_a), 31);
    @(negedge clk);
    check("sat_cnt_1", int'(c1_a), 31);
    coin_in_type = 2'b00;
    @(negedge clk);
    check("ign_cnt_10", int'(c10_a), 8);
    check("ign_cnt_5", int'(c5_a), 8);
    coin_in_type = 2'b11;
    @(negedge clk);
    check("ins_cnt_10", int'(c10_a), 9);
    coin_in_valid = 1'b0; coin_in_type = 2'b00;

    // Reset while an eject is pending: eject_valid drops at once, no done pulse.
    apply_reset();
    @(negedge clk);
    req_valid_a = 1'b1; req_amount = AMT_W'(37);
    acks = 0;
    for (int cyc = 0; cyc < 50 && acks < 2; cyc++) begin
      @(negedge clk);
      req_valid_a = 1'b0;
      eject_ack = 1'b0;
      if (ev_a) begin eject_ack = 1'b1; acks++; end
    end
    @(negedge clk);
    eject_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_eject_vld", int'(ev_a), 1);
    check("pre_rst_cnt_10", int'(c10_a), 6);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_eject_vld", int'(ev_a), 0);
    check("mid_rst_cnt_10", int'(c10_a), 8);
    check("mid_rst_cnt_5", int'(c5_a), 8);
    check("mid_rst_cnt_1", int'(c1_a), 10);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (done_a) seen_done++;
    end
    check("mid_rst_no_done", seen_done, 0);
    check("mid_rst_ready", int'(ready_a), 1);

`ifdef CHANGE_DISPENSE_ACK_TIMEOUT_EN
    // Mechanism never acks: 15 EJECT cycles, then done with the full remainder.
    apply_reset();
    run_req(1'b0, 12, NEVER, 2'b00);
    check("tmo_short", r_short, 12);
    check("tmo_latency", r_lat, 17);
    check("tmo_fault", int'(fault_a), 1);
    @(negedge clk);
    check("tmo_cnt_10", int'(c10_a), 8);
    check("tmo_eject_vld", int'(ev_a), 0);
    run_req(1'b0, 5, 0, 2'b00);
    check("tmo_next_short", r_short, 0);
    check("tmo_fault_sticky", int'(fault_a), 1);
    @(negedge clk);
    check("tmo_next_cnt_5", int'(c5_a), 7);
`else
    // Without the timeout, a long ack wait is simply waited out.
    apply_reset();
    run_req(1'b0, 12, 40, 2'b00);
    check("slow_n10", r_n10, 1);
    check("slow_n1", r_n1, 2);
    check("slow_short", r_short, 0);
    check("slow_stable", r_stable, 1);
    check("slow_fault", int'(fault_a), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
